ibex_prefetch_ctrl: RTL and testbench

Sequencing controller for the instruction fetch FIFO. It issues word-aligned instruction requests on the OBI-style instruction memory port and tracks up to NUM_REQS outstanding transactions. It discards responses made stale by a branch and pushes surviving responses into the fetch FIFO. It throttles new requests using FIFO occupancy so that the FIFO can never overflow.

---
 rtl/ibex_prefetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ibex_prefetch_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ibex_prefetch_ctrl.sv
// Fetch sequencing controller: issues word-aligned instruction requests, tracks
// up to NUM_REQS outstanding transactions, drops responses made stale by a
// branch and pushes the rest into the fetch FIFO without ever overflowing it.
module ibex_prefetch_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o
);

  typedef enum logic {StIdle, StWaitGnt} state_e;

  state_e              state_q, state_d;
  logic [31:0]         fetch_addr_q, fetch_addr_d;
  logic [31:0]         stored_addr_q, stored_addr_d;
  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic                branch_pending_q, branch_pending_d;

  logic [31:0]         branch_addr;
  logic [NUM_REQS-1:0] outstanding_rev;
  logic                fifo_ready;
  logic                room;
  logic                new_req;
  logic                gnt_fire;
  logic                new_discard;
  logic [NUM_REQS-1:0] out_shift;
  logic [NUM_REQS-1:0] disc_shift;
  logic [NUM_REQS-1:0] set_mask;
  logic                slot_found;

  assign branch_addr = {addr_i[31:2], 2'b00};

  // Passthroughs to the FIFO
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;

  // Bit-reverse outstanding so the oldest transactions line up with the
  // highest FIFO entries they will eventually occupy.
  always_comb begin
    outstanding_rev = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      outstanding_rev[i] = outstanding_q[int'(NUM_REQS) - 1 - i];
    end
  end

  assign fifo_ready = ~&(fifo_busy_i | outstanding_rev);
  // A branch clears the FIFO, so occupancy does not matter then.
  assign room       = fifo_ready | branch_i;
  assign new_req    = req_i & room & ~outstanding_q[NUM_REQS-1];

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (new_req && !instr_gnt_i) state_d = StWaitGnt;
      StWaitGnt: if (instr_gnt_i) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs: request is held stable while waiting for the grant
  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    unique case (state_q)
      StIdle: begin
        instr_req_o  = new_req;
        instr_addr_o = branch_i ? branch_addr : fetch_addr_q;
      end
      StWaitGnt: begin
        instr_req_o  = 1'b1;
        instr_addr_o = stored_addr_q;
      end
      default: begin
        instr_req_o  = 1'b0;
        instr_addr_o = fetch_addr_q;
      end
    endcase
  end

  assign gnt_fire = instr_req_o & instr_gnt_i;

  // A request granted from WAIT_GNT is stale if any branch arrived while it
  // waited, including in the grant cycle itself; one from IDLE never is.
  assign new_discard = (state_q == StWaitGnt) ? (branch_pending_q | branch_i) : 1'b0;

  // Retire the response first, then allocate the lowest free slot.
  always_comb begin
    out_shift  = instr_rvalid_i ? (outstanding_q >> 1) : outstanding_q;
    disc_shift = instr_rvalid_i ? (discard_q >> 1) : discard_q;
    if (branch_i) disc_shift = disc_shift | out_shift;
    set_mask   = '0;
    slot_found = 1'b0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (!slot_found && !out_shift[i]) begin
        set_mask[i] = 1'b1;
        slot_found  = 1'b1;
      end
    end
    outstanding_d = out_shift;
    discard_d     = disc_shift;
    if (gnt_fire) begin
      outstanding_d = out_shift | set_mask;
      discard_d     = (disc_shift & ~set_mask) | (new_discard ? set_mask : '0);
    end
  end

  // Fetch address, stored request address and pending-branch tracking
  always_comb begin
    fetch_addr_d     = fetch_addr_q;
    stored_addr_d    = stored_addr_q;
    branch_pending_d = 1'b0;
    if (branch_i) begin
      fetch_addr_d = branch_addr + ((gnt_fire && state_q == StIdle) ? 32'd4 : 32'd0);
    end else if (gnt_fire && !branch_pending_q) begin
      // A pending branch already set the next address; don't overwrite it.
      fetch_addr_d = instr_addr_o + 32'd4;
    end
    if (state_q == StIdle && new_req && !instr_gnt_i) begin
      stored_addr_d = instr_addr_o;
    end
    if (state_q == StWaitGnt && !instr_gnt_i) begin
      branch_pending_d = branch_pending_q | branch_i;
    end
  end

  // Datapath state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_addr_q     <= '0;
      stored_addr_q    <= '0;
      outstanding_q    <= '0;
      discard_q        <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      fetch_addr_q     <= fetch_addr_d;
      stored_addr_q    <= stored_addr_d;
      outstanding_q    <= outstanding_d;
      discard_q        <= discard_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~discard_q[0] & ~branch_i;
  assign busy_o       = (|outstanding_q) | instr_req_o;

`ifndef SYNTHESIS
  rvalid_has_owner: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> outstanding_q[0]);
  fifo_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (fifo_valid_o && !fifo_clear_o) |-> !fifo_busy_i[NUM_REQS-1]);
`endif

endmodule

// File: tb/tb_ibex_prefetch_ctrl.sv
// Scoreboard bench for ibex_prefetch_ctrl: directed stimulus queues expected
// grant addresses and FIFO pushes; a monitor pops and compares them.
module tb_ibex_prefetch_ctrl;
  localparam int unsigned NUM_REQS = 2;
  localparam logic [31:0] KEY = 32'hDEAD_0000;

  logic          clk, rst, req, branch, busy, instr_req, gnt;
  logic [31:0]   addr, instr_addr, rdata, fifo_addr, fifo_rdata;
  logic          rvalid, err, fifo_clear, fifo_valid, fifo_err;
  logic [NUM_REQS-1:0] fifo_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_addr_q[$];
  logic [32:0] exp_push_q[$];
  logic [31:0] mem_q[$];
  logic        rsp_hold, mem_flush;
  logic [31:0] err_addr;

  ibex_prefetch_ctrl #(.NUM_REQS(NUM_REQS)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(branch), .addr_i(addr),
    .busy_o(busy), .instr_req_o(instr_req), .instr_gnt_i(gnt), .instr_addr_o(instr_addr),
    .instr_rvalid_i(rvalid), .instr_rdata_i(rdata), .instr_err_i(err),
    .fifo_clear_o(fifo_clear), .fifo_busy_i(fifo_busy), .fifo_valid_o(fifo_valid),
    .fifo_addr_o(fifo_addr), .fifo_rdata_o(fifo_rdata), .fifo_err_o(fifo_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic r, input logic b, input logic [31:0] a, input logic g);
    req    = r;
    branch = b;
    addr   = a;
    gnt    = g;
  endtask

  // Expect a grant at address a; if pushed, also expect its FIFO push.
  task automatic expect_req(input logic [31:0] a, input logic pushed, input logic e);
    exp_addr_q.push_back(a);
    if (pushed) exp_push_q.push_back({e, a ^ KEY});
  endtask

  // Memory model: answers each grant one cycle later, in order, unless held.
  initial begin
    logic [31:0] a;
    rvalid = 1'b0;
    rdata  = '0;
    err    = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_flush) mem_q.delete();
      if (!rsp_hold && mem_q.size() > 0) begin
        a      = mem_q.pop_front();
        rvalid = 1'b1;
        rdata  = a ^ KEY;
        err    = (a == err_addr);
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        err    = 1'b0;
      end
      @(negedge clk);
      if (!rst && instr_req && gnt) mem_q.push_back(instr_addr);
    end
  end

  // Monitor: compares every grant and every FIFO push against the scoreboard.
  initial begin
    logic [31:0] ea;
    logic [32:0] ep;
    forever begin
      @(negedge clk);
      if (!rst && instr_req === 1'b1 && gnt === 1'b1) begin
        if (exp_addr_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant_addr: unexpected grant at %h, required none", instr_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          chk("grant_addr", instr_addr, ea);
        end
      end
      if (!rst && fifo_valid === 1'b1) begin
        if (exp_push_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL push: unexpected push of %h, required none", fifo_rdata);
        end else begin
          ep = exp_push_q.pop_front();
          chk("push_data", fifo_rdata, ep[31:0]);
          chk("push_err", {31'b0, fifo_err}, {31'b0, ep[32]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; fifo_busy = '0; rsp_hold = 1'b0; mem_flush = 1'b0;
    err_addr = 32'hFFFF_FFFF;
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    step(); step();
    rst = 1'b0;
    #3;
    chk("rst_req", {31'b0, instr_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, fifo_valid}, 32'd0);
    step();

    // 1: branch to 0x102, grant every cycle, responses one cycle later
    set_in(1'b1, 1'b1, 32'h102, 1'b1); expect_req(32'h100, 1'b1, 1'b0);
    #3;
    chk("t1_clear", {31'b0, fifo_clear}, 32'd1);
    chk("t1_fifo_addr", fifo_addr, 32'h102);
    step();
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h104, 1'b1, 1'b0); step();
    expect_req(32'h108, 1'b1, 1'b0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step();
    #3; chk("t1_idle_busy", {31'b0, busy}, 32'd0); step();

    // 2: grant withheld three cycles, branch to 0x200 while waiting
    set_in(1'b1, 1'b1, 32'h100, 1'b0);
    #3; chk("t2_addr_c1", instr_addr, 32'h100); step();
    set_in(1'b1, 1'b0, 32'h0, 1'b0);
    #3; chk("t2_req_c2", {31'b0, instr_req}, 32'd1); chk("t2_addr_c2", instr_addr, 32'h100);
    step();
    set_in(1'b1, 1'b1, 32'h200, 1'b0);
    #3; chk("t2_addr_c3", instr_addr, 32'h100); step();
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h100, 1'b0, 1'b0); step();
    expect_req(32'h200, 1'b1, 1'b0);
    #3; chk("t2_stale_dropped", {31'b0, fifo_valid}, 32'd0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); step();

    // 3: two outstanding, no responses: request throttled until one returns
    rsp_hold = 1'b1;
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h204, 1'b1, 1'b0); step();
    expect_req(32'h208, 1'b1, 1'b0); step();
    #3; chk("t3_full_c3", {31'b0, instr_req}, 32'd0); chk("t3_busy", {31'b0, busy}, 32'd1);
    step();
    #3; chk("t3_full_c4", {31'b0, instr_req}, 32'd0); step();
    rsp_hold = 1'b0;
    #3; chk("t3_rvalid_cycle", {31'b0, instr_req}, 32'd0); step();
    expect_req(32'h20C, 1'b1, 1'b0);
    #3; chk("t3_after_rvalid", {31'b0, instr_req}, 32'd1); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); step();

    // 4: FIFO busy blocks fetch; branch issues anyway and drops the old response
    rsp_hold = 1'b1;
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h210, 1'b0, 1'b0); step();
    fifo_busy = 2'b11;
    #3; chk("t4_blocked_c2", {31'b0, instr_req}, 32'd0); step();
    #3; chk("t4_blocked_c3", {31'b0, instr_req}, 32'd0); chk("t4_busy", {31'b0, busy}, 32'd1);
    step();
    set_in(1'b1, 1'b1, 32'h300, 1'b1); expect_req(32'h300, 1'b1, 1'b0);
    #3; chk("t4_branch_req", {31'b0, instr_req}, 32'd1); step();
    fifo_busy = 2'b00; rsp_hold = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b0);
    #3; chk("t4_stale_dropped", {31'b0, fifo_valid}, 32'd0); step();
    step(); step();

    // 5: bus error response is still pushed and fetching continues
    err_addr = 32'h304;
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h304, 1'b1, 1'b1); step();
    expect_req(32'h308, 1'b1, 1'b0);
    #3; chk("t5_valid", {31'b0, fifo_valid}, 32'd1); chk("t5_err", {31'b0, fifo_err}, 32'd1);
    step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); step();

    // 6: reset with two outstanding drops all tracking
    rsp_hold = 1'b1;
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h30C, 1'b0, 1'b0); step();
    expect_req(32'h310, 1'b0, 1'b0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); rst = 1'b1; mem_flush = 1'b1; step();
    rst = 1'b0; mem_flush = 1'b0; rsp_hold = 1'b0;
    #3; chk("t6_req", {31'b0, instr_req}, 32'd0); chk("t6_busy", {31'b0, busy}, 32'd0); step();
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h0, 1'b1, 1'b0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); step();

    // 7: fetch address wraps modulo 2^32
    set_in(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1); expect_req(32'hFFFF_FFFC, 1'b1, 1'b0); step();
    set_in(1'b1, 1'b0, 32'h0, 1'b1); expect_req(32'h0, 1'b1, 1'b0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); step();

    chk("addr_queue_drained", exp_addr_q.size(), 32'd0);
    chk("push_queue_drained", exp_push_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
